hdmi_tx_timing_gen: RTL and testbench

- Parametrised video timing generator and output stage for the HDMI transmit path; successor to the fixed 1080p60 sync generator and output register.
- Resolution, porches, sync polarity, prefetch lead, colour width and test-pattern modes are all configurable.
- Issues a lead-time pixel request to the upstream DDR3 read FIFO and registers sync and RGB toward the HDMI TX chip.
- Detects FIFO underflow during active video.

---
 rtl/hdmi_tx_timing_gen.sv | 235 +++++++++++++++++++++++
 tb/tb_hdmi_tx_timing_gen.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_tx_timing_gen.sv
// hdmi_tx_timing_gen: parametrised video timing generator and HDMI TX output
// stage. Issues a lead-time pixel request to the upstream read FIFO, carries
// the request-position sync/enable/coordinates through a LEAD-deep delay line
// and registers sync and RGB toward the TX chip. Flags FIFO underflow during
// pass-through active video.
module hdmi_tx_timing_gen #(
  parameter int CW       = 8,
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int LEAD     = 2,
  parameter int CNT_W    = 12
) (
  input  logic            pix_clk,
  input  logic            rst,
  input  logic            init_over,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] solid_rgb,
  input  logic [3*CW-1:0] pix_in,
  input  logic            pix_in_vld,
  input  logic            err_clr,
  output logic            pix_req,
  output logic            frame_req_start,
  output logic            vs_out,
  output logic            hs_out,
  output logic            de_out,
  output logic [CW-1:0]   r_out,
  output logic [CW-1:0]   g_out,
  output logic [CW-1:0]   b_out,
  output logic            underflow,
  output logic [15:0]     underflow_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_ON  = 1'(HS_POL);
  localparam logic             VS_ON  = 1'(VS_POL);

  // Colour-bar pattern: white, yellow, cyan, green, magenta, red, blue, black;
  // anything past the last full bar falls into the black slot.
  function automatic logic [3*CW-1:0] f_bar(input logic [CNT_W-1:0] x);
    logic [2:0] idx;
    logic [2:0] c;
    idx = '0;
    for (int i = 1; i < 8; i++)
      if (int'(x) >= i * BAR_W) idx = 3'(i);
    case (idx)
      3'd0:    c = 3'b111;
      3'd1:    c = 3'b110;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b010;
      3'd4:    c = 3'b101;
      3'd5:    c = 3'b100;
      3'd6:    c = 3'b001;
      default: c = 3'b000;
    endcase
    return {{CW{c[2]}}, {CW{c[1]}}, {CW{c[0]}}};
  endfunction

  // Grid pattern: white lines every 32 pixels/lines.
  function automatic logic [3*CW-1:0] f_grid(input logic [4:0] x, input logic [4:0] y);
    return (x == 5'd0 || y == 5'd0) ? {3*CW{1'b1}} : {3*CW{1'b0}};
  endfunction

  logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
  logic [1:0]       r_mode;
  logic             w_de_i, w_hs_i, w_vs_i, w_sof, w_wrap;

  logic             r_de_p0, r_hs_p0, r_vs_p0, r_sof_p0;
  logic [CNT_W-1:0] r_x_p0;
  logic [4:0]       r_y_p0;

  logic             r_de_dl [LEAD];
  logic             r_hs_dl [LEAD];
  logic             r_vs_dl [LEAD];
  logic [CNT_W-1:0] r_x_dl  [LEAD];
  logic [4:0]       r_y_dl  [LEAD];

  logic             w_de_d, w_hs_d, w_vs_d, w_uf;
  logic [CNT_W-1:0] w_x_d;
  logic [4:0]       w_y_d;
  logic [3*CW-1:0]  w_rgb;

  logic             r_vs_out, r_hs_out, r_de_out, r_uf;
  logic [3*CW-1:0]  r_rgb_out;
  logic [15:0]      r_uf_cnt;

  assign w_de_i = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_i = (r_h_cnt >= H_SS) && (r_h_cnt < H_SE);
  assign w_vs_i = (r_v_cnt >= V_SS) && (r_v_cnt < V_SE);
  assign w_sof  = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_wrap = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);

  // Horizontal/vertical position counters (request position).
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CNT_W'(1);
    end else begin
      r_h_cnt <= r_h_cnt + CNT_W'(1);
    end
  end

  // Pattern mode is latched only at the frame boundary so a frame never tears.
  always_ff @(posedge pix_clk) begin
    if (rst)         r_mode <= 2'd0;
    else if (w_wrap) r_mode <= mode;
  end

  // Stage p0: registered request-position signals; de_p0 doubles as pix_req.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      r_de_p0  <= 1'b0;
      r_hs_p0  <= 1'b0;
      r_vs_p0  <= 1'b0;
      r_sof_p0 <= 1'b0;
      r_x_p0   <= '0;
      r_y_p0   <= '0;
    end else begin
      r_de_p0  <= w_de_i;
      r_hs_p0  <= w_hs_i;
      r_vs_p0  <= w_vs_i;
      r_sof_p0 <= w_sof;
      r_x_p0   <= r_h_cnt;
      r_y_p0   <= r_v_cnt[4:0];
    end
  end

  // Stage p1..pLEAD: delay line matching the upstream FIFO read latency.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      for (int i = 0; i < LEAD; i++) begin
        r_de_dl[i] <= 1'b0;
        r_hs_dl[i] <= 1'b0;
        r_vs_dl[i] <= 1'b0;
        r_x_dl[i]  <= '0;
        r_y_dl[i]  <= '0;
      end
    end else begin
      r_de_dl[0] <= r_de_p0;
      r_hs_dl[0] <= r_hs_p0;
      r_vs_dl[0] <= r_vs_p0;
      r_x_dl[0]  <= r_x_p0;
      r_y_dl[0]  <= r_y_p0;
      for (int i = 1; i < LEAD; i++) begin
        r_de_dl[i] <= r_de_dl[i-1];
        r_hs_dl[i] <= r_hs_dl[i-1];
        r_vs_dl[i] <= r_vs_dl[i-1];
        r_x_dl[i]  <= r_x_dl[i-1];
        r_y_dl[i]  <= r_y_dl[i-1];
      end
    end
  end

  assign w_de_d = r_de_dl[LEAD-1];
  assign w_hs_d = r_hs_dl[LEAD-1];
  assign w_vs_d = r_vs_dl[LEAD-1];
  assign w_x_d  = r_x_dl[LEAD-1];
  assign w_y_d  = r_y_dl[LEAD-1];

  // Pixel source selection and underflow detection in the consume cycle.
  always_comb begin
    w_uf  = (r_mode == 2'd0) && w_de_d && !pix_in_vld;
    w_rgb = '0;
    if (w_de_d) begin
      case (r_mode)
        2'd0:    if (pix_in_vld) w_rgb = pix_in;
        2'd1:    w_rgb = f_bar(w_x_d);
        2'd2:    w_rgb = solid_rgb;
        default: w_rgb = f_grid(w_x_d[4:0], w_y_d);
      endcase
    end
  end

  // Output register toward the TX chip; held at 0 until the chip is configured.
  always_ff @(posedge pix_clk) begin
    if (rst || !init_over) begin
      r_vs_out  <= 1'b0;
      r_hs_out  <= 1'b0;
      r_de_out  <= 1'b0;
      r_rgb_out <= '0;
    end else begin
      r_vs_out  <= w_vs_d ? VS_ON : ~VS_ON;
      r_hs_out  <= w_hs_d ? HS_ON : ~HS_ON;
      r_de_out  <= w_de_d;
      r_rgb_out <= w_rgb;
    end
  end

  // Sticky underflow flag and saturating count; a clear loses to a new event.
  always_ff @(posedge pix_clk) begin
    if (rst) begin
      r_uf     <= 1'b0;
      r_uf_cnt <= '0;
    end else if (err_clr) begin
      r_uf     <= w_uf;
      r_uf_cnt <= w_uf ? 16'd1 : 16'd0;
    end else if (w_uf) begin
      r_uf <= 1'b1;
      if (r_uf_cnt != 16'hFFFF) r_uf_cnt <= r_uf_cnt + 16'd1;
    end
  end

  assign pix_req         = r_de_p0;
  assign frame_req_start = r_sof_p0;
  assign vs_out          = r_vs_out;
  assign hs_out          = r_hs_out;
  assign de_out          = r_de_out;
  assign r_out           = r_rgb_out[3*CW-1:2*CW];
  assign g_out           = r_rgb_out[2*CW-1:CW];
  assign b_out           = r_rgb_out[CW-1:0];
  assign underflow       = r_uf;
  assign underflow_cnt   = r_uf_cnt;

endmodule

// File: tb/tb_hdmi_tx_timing_gen.sv
// Testbench for hdmi_tx_timing_gen using a small 24x12 timing with LEAD=2.
// Two instances: positive sync polarity (dut) and negative polarity (dut_n).
module tb_hdmi_tx_timing_gen;
  localparam int LEAD  = 2;
  localparam int FRAME = 288;

  logic        clk = 1'b0;
  logic        rst, init_over, pix_in_vld, err_clr;
  logic [1:0]  mode;
  logic [23:0] solid_rgb, pix_in;

  logic        pix_req, frame_req_start, vs_out, hs_out, de_out, underflow;
  logic [7:0]  r_out, g_out, b_out;
  logic [15:0] underflow_cnt;
  logic        pix_req_n, frs_n, vs_n, hs_n, de_n, uf_n;
  logic [7:0]  r_n, g_n, b_n;
  logic [15:0] ufc_n;

  int          checks = 0;
  int          errors = 0;
  int          tcount = 0;
  int          sb_pops = 0;
  bit          sb_en = 0;
  bit          vld_drv = 1;
  bit          clr_drv = 0;
  bit          hist [9];
  logic [23:0] sb_q [$];

  always #5 clk = ~clk;

  hdmi_tx_timing_gen #(.CW(8), .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(2), .HS_POL(1), .VS_POL(1),
    .LEAD(LEAD), .CNT_W(12)) dut (
    .pix_clk(clk), .rst(rst), .init_over(init_over), .mode(mode),
    .solid_rgb(solid_rgb), .pix_in(pix_in), .pix_in_vld(pix_in_vld), .err_clr(err_clr),
    .pix_req(pix_req), .frame_req_start(frame_req_start), .vs_out(vs_out),
    .hs_out(hs_out), .de_out(de_out), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .underflow(underflow), .underflow_cnt(underflow_cnt));

  hdmi_tx_timing_gen #(.CW(8), .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(2), .HS_POL(0), .VS_POL(0),
    .LEAD(LEAD), .CNT_W(12)) dut_n (
    .pix_clk(clk), .rst(rst), .init_over(init_over), .mode(mode),
    .solid_rgb(solid_rgb), .pix_in(pix_in), .pix_in_vld(pix_in_vld), .err_clr(err_clr),
    .pix_req(pix_req_n), .frame_req_start(frs_n), .vs_out(vs_n),
    .hs_out(hs_n), .de_out(de_n), .r_out(r_n), .g_out(g_n), .b_out(b_n),
    .underflow(uf_n), .underflow_cnt(ufc_n));

  // One clock: sample after the edge, pop/compare the scoreboard, drive inputs,
  // and push the expected pass-through pixel for requests issued LEAD clks ago.
  task automatic tick();
    logic [23:0] exp;
    @(posedge clk); #1;
    tcount++;
    if (sb_en && de_out) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: de_out at tick %0d with no expected pixel", tcount);
      end else begin
        exp = sb_q.pop_front();
        sb_pops++;
        if ({r_out, g_out, b_out} !== exp) begin
          errors++;
          $display("FAIL sb_pixel: tick %0d got %06h expected %06h", tcount, {r_out, g_out, b_out}, exp);
        end
      end
    end
    for (int i = 8; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pix_req;
    pix_in     = pix_in + 24'd1;
    pix_in_vld = vld_drv;
    err_clr    = clr_drv;
    if (sb_en && hist[LEAD]) sb_q.push_back(vld_drv ? pix_in : 24'h0);
  endtask

  task automatic do_reset();
    sb_en = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tcount = 0;
    sb_pops = 0;
    sb_q.delete();
    for (int i = 0; i < 9; i++) hist[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks += 6;
    if (pix_req !== 1'b0) begin errors++; $display("FAIL rst_pix_req: got %b expected 0", pix_req); end
    if (frame_req_start !== 1'b0) begin errors++; $display("FAIL rst_frs: got %b expected 0", frame_req_start); end
    if ({vs_out, hs_out, de_out} !== 3'b000) begin errors++; $display("FAIL rst_sync: got %b expected 000", {vs_out, hs_out, de_out}); end
    if ({r_out, g_out, b_out} !== 24'h0) begin errors++; $display("FAIL rst_rgb: got %06h expected 0", {r_out, g_out, b_out}); end
    if ({underflow, underflow_cnt} !== 17'h0) begin errors++; $display("FAIL rst_uf: got %0h expected 0", {underflow, underflow_cnt}); end
    if ({vs_n, hs_n, de_n, r_n, g_n, b_n} !== 27'h0) begin errors++; $display("FAIL rst_n_out: got %0h expected 0", {vs_n, hs_n, de_n, r_n, g_n, b_n}); end
    rst = 1'b0;
    tick();
    checks++;
    if (frame_req_start !== 1'b1) begin errors++; $display("FAIL rst_first_frs: got %b expected 1", frame_req_start); end
  endtask

  task automatic test_timing();
    int first_req, first_de, last_hs, hs_hi, vs_hi, de_hi, de_rise;
    bit prev_hs, prev_de;
    first_req = -1; first_de = -1; last_hs = -1;
    hs_hi = 0; vs_hi = 0; de_hi = 0; de_rise = 0; prev_hs = 0; prev_de = 0;
    mode = 2'd0; vld_drv = 1; clr_drv = 0;
    do_reset();
    sb_en = 1;
    for (int t = 1; t <= 2 * FRAME; t++) begin
      tick();
      if (pix_req && first_req < 0) first_req = tcount;
      if (de_out && first_de < 0) first_de = tcount;
      if (hs_out && !prev_hs) begin
        if (last_hs >= 0) begin
          checks++;
          if (tcount - last_hs != 24) begin errors++; $display("FAIL hs_period: got %0d expected 24", tcount - last_hs); end
        end
        last_hs = tcount;
      end
      if (tcount > FRAME) begin
        hs_hi += int'(hs_out);
        vs_hi += int'(vs_out);
        de_hi += int'(de_out);
        if (de_out && !prev_de) de_rise++;
      end
      prev_hs = hs_out;
      prev_de = de_out;
    end
    checks += 7;
    if (first_de - first_req != LEAD + 1) begin errors++; $display("FAIL de_latency: got %0d expected %0d", first_de - first_req, LEAD + 1); end
    if (hs_hi != 24) begin errors++; $display("FAIL hs_high: got %0d expected 24", hs_hi); end
    if (vs_hi != 24) begin errors++; $display("FAIL vs_high: got %0d expected 24", vs_hi); end
    if (de_hi != 128) begin errors++; $display("FAIL de_count: got %0d expected 128", de_hi); end
    if (de_rise != 8) begin errors++; $display("FAIL de_lines: got %0d expected 8", de_rise); end
    if (sb_pops != 256) begin errors++; $display("FAIL pixel_count: got %0d expected 256", sb_pops); end
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d expected 0", sb_q.size()); end
    sb_en = 0;
  endtask

  task automatic test_underflow();
    mode = 2'd0; vld_drv = 1; clr_drv = 0;
    do_reset();
    sb_en = 1;
    for (int t = 1; t <= FRAME; t++) begin
      vld_drv = (t < 5 || t > 9);
      tick();
    end
    checks += 2;
    if (underflow !== 1'b1) begin errors++; $display("FAIL uf_flag: got %b expected 1", underflow); end
    if (underflow_cnt !== 16'd5) begin errors++; $display("FAIL uf_cnt: got %0d expected 5", underflow_cnt); end
    for (int t = FRAME + 1; t <= 2 * FRAME; t++) begin
      vld_drv = (t != FRAME + 5);
      clr_drv = (t == FRAME + 5 || t == FRAME + 12);
      tick();
      if (tcount == FRAME + 6 || tcount == FRAME + 8) begin
        checks++;
        if ({underflow, underflow_cnt} !== {1'b1, 16'd1}) begin
          errors++; $display("FAIL uf_clr_coincident: got %b/%0d expected 1/1", underflow, underflow_cnt);
        end
      end
      if (tcount == FRAME + 13) begin
        checks++;
        if ({underflow, underflow_cnt} !== 17'h0) begin
          errors++; $display("FAIL uf_clr: got %b/%0d expected 0/0", underflow, underflow_cnt);
        end
      end
    end
    clr_drv = 0; vld_drv = 1;
    checks++;
    if (sb_pops != 256) begin errors++; $display("FAIL uf_pixel_count: got %0d expected 256", sb_pops); end
    sb_en = 0;
  endtask

  task automatic test_mode_switch();
    logic [23:0] bars [8];
    int x, nde;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    mode = 2'd0; vld_drv = 1; clr_drv = 0;
    do_reset();
    sb_en = 1;
    for (int t = 1; t <= FRAME; t++) begin
      if (t == 50) mode = 2'd1;
      tick();
    end
    checks++;
    if (sb_pops != 128) begin errors++; $display("FAIL mode_old_frame: got %0d pixels expected 128", sb_pops); end
    sb_en = 0;
    nde = 0;
    for (int t = FRAME + 1; t <= FRAME + 24; t++) begin
      vld_drv = 0;
      if (t == FRAME + 12) mode = 2'd2;
      tick();
      if (de_out) begin
        x = tcount - (FRAME + LEAD + 2);
        nde++;
        checks++;
        if (x < 0 || x > 15 || {r_out, g_out, b_out} !== bars[x / 2]) begin
          errors++; $display("FAIL bars_x%0d: got %06h expected %06h", x, {r_out, g_out, b_out}, bars[(x & 15) / 2]);
        end
      end
    end
    vld_drv = 1;
    checks += 2;
    if (nde != 16) begin errors++; $display("FAIL bars_width: got %0d expected 16", nde); end
    if (underflow !== 1'b0) begin errors++; $display("FAIL bars_no_uf: got %b expected 0", underflow); end
    while (tcount < 2 * FRAME + LEAD + 2) tick();
    checks++;
    if ({de_out, r_out, g_out, b_out} !== {1'b1, solid_rgb}) begin
      errors++; $display("FAIL solid: got %b/%06h expected 1/%06h", de_out, {r_out, g_out, b_out}, solid_rgb);
    end
    mode = 2'd0;
  endtask

  task automatic test_pol_init();
    int bad, rises, lows, lows_p;
    bit prev_req;
    bad = 0; rises = 0; lows = 0; lows_p = 0; prev_req = 0;
    mode = 2'd0; vld_drv = 1; clr_drv = 0;
    init_over = 1'b0;
    do_reset();
    for (int t = 1; t <= 48; t++) begin
      tick();
      if ({vs_n, hs_n, de_n, r_n, g_n, b_n, vs_out, hs_out, de_out, r_out, g_out, b_out} != '0) bad++;
      if (pix_req_n && !prev_req) rises++;
      prev_req = pix_req_n;
    end
    checks += 2;
    if (bad != 0) begin errors++; $display("FAIL init_hold: got %0d nonzero ticks expected 0", bad); end
    if (rises != 2) begin errors++; $display("FAIL init_req: got %0d pix_req rises expected 2", rises); end
    init_over = 1'b1;
    for (int t = 49; t <= 96; t++) begin
      tick();
      if (tcount == 49) begin
        checks++;
        if ({vs_n, hs_n} !== 2'b11) begin errors++; $display("FAIL neg_idle: got %b expected 11", {vs_n, hs_n}); end
      end
      if (!hs_n) lows++;
      if (hs_out) lows_p++;
    end
    checks += 2;
    if (lows != 4) begin errors++; $display("FAIL neg_hs_pulse: got %0d low clks expected 4", lows); end
    if (lows_p != 4) begin errors++; $display("FAIL pos_hs_pulse: got %0d high clks expected 4", lows_p); end
  endtask

  task automatic test_reset_midline();
    mode = 2'd0; vld_drv = 1; clr_drv = 0; init_over = 1'b1;
    do_reset();
    for (int t = 1; t <= 30; t++) begin
      vld_drv = (t < 5 || t > 6);
      tick();
    end
    vld_drv = 1;
    checks++;
    if (underflow_cnt !== 16'd2) begin errors++; $display("FAIL pre_rst_cnt: got %0d expected 2", underflow_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 4;
    if ({pix_req, frame_req_start} !== 2'b00) begin errors++; $display("FAIL mid_rst_req: got %b expected 00", {pix_req, frame_req_start}); end
    if ({vs_out, hs_out, de_out} !== 3'b000) begin errors++; $display("FAIL mid_rst_sync: got %b expected 000", {vs_out, hs_out, de_out}); end
    if ({r_out, g_out, b_out} !== 24'h0) begin errors++; $display("FAIL mid_rst_rgb: got %06h expected 0", {r_out, g_out, b_out}); end
    if ({underflow, underflow_cnt} !== 17'h0) begin errors++; $display("FAIL mid_rst_uf: got %b/%0d expected 0/0", underflow, underflow_cnt); end
    tick();
    checks += 2;
    if (frame_req_start !== 1'b1) begin errors++; $display("FAIL mid_rst_frs: got %b expected 1", frame_req_start); end
    if (pix_req !== 1'b1) begin errors++; $display("FAIL mid_rst_req1: got %b expected 1", pix_req); end
    tick();
    checks++;
    if (frame_req_start !== 1'b0) begin errors++; $display("FAIL mid_rst_frs_pulse: got %b expected 0", frame_req_start); end
  endtask

  initial begin
    rst = 1'b1; init_over = 1'b1; mode = 2'd0; solid_rgb = 24'h123456;
    pix_in = 24'h0; pix_in_vld = 1'b1; err_clr = 1'b0;
    test_reset();
    test_timing();
    test_underflow();
    test_mode_switch();
    test_pol_init();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
